spi_master_multi: RTL and testbench
===================================

Name: spi_master_multi

Overview:
Parametrised SPI master serving NUM_CS devices (flash, SD, future peripherals) from one shared SCLK/MOSI, with per-device MISO selection.
Adds the following:
- programmable SCLK divider
- SPI modes 0-3
- hardware-exclusive chip selects
- chip-select writes deferred while a transfer is in progress

Sits between the CPU I/O decode (register/port strobes) and the board SPI pins.

Parameters:
NUM_CS, 2, number of chip-select outputs (1..8)
CS_IDX_W, 1, width of cs_idx; must be ≥ clog2(NUM_CS), min 1
DIV_W, 8, width of the clock divider register
DEFAULT_DIV, 0, divider value loaded at reset
DEFAULT_MODE, 0, SPI mode {CPOL,CPHA} loaded at reset

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cs_we  in  1  chip-select write strobe, one clk
cs_idx  in  CS_IDX_W  device index for cs_we
cs_level  in  1  level written to spi_cs_n[cs_idx]
div_we  in  1  divider write strobe
div_in  in  DIV_W  new divider value
mode_we  in  1  mode write strobe
mode_in  in  2  new {CPOL,CPHA}
tx_we  in  1  start transfer sending din
rx_re  in  1  read last byte; start dummy transfer sending 8'hFF
din  in  8  transmit byte
dout  out  8  last received byte
oe  out  1  dout valid (equals rx_re)
busy  out  1  transfer in progress
wait_n  out  1  ~busy, CPU wait
spi_clk  out  1  SCLK
spi_mosi  out  1  MOSI
spi_miso  in  NUM_CS  MISO per device
spi_cs_n  out  NUM_CS  active-low chip selects

Behaviour:
- Reset (async, any time, including mid-transfer; aborts the transfer):
  - spi_cs_n all 1, spi_clk=CPOL, spi_mosi=1, busy=0
  - rx_data=8'hFF, div=DEFAULT_DIV, mode=DEFAULT_MODE, pending CS cleared
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - tx_we loads the shift register with din; rx_re alone loads 8'hFF.
  - Next state SHIFT; busy=1 from the next clk.
  - tx_we and rx_re together: transmit din; dout still shows the old rx_data.
- SHIFT:
  - Half-period counter runs 0..div; each wrap toggles spi_clk (16 toggles per byte).
  - One byte takes exactly 16*(div+1) clk cycles in SHIFT.
  - MSB first.
  - CPHA=0: MOSI bit 7 is valid on entry to SHIFT; sample on odd toggles (leading edge), shift on even toggles.
  - CPHA=1: shift on odd toggles, sample on even toggles.
  - After the 16th toggle go to FINISH; spi_clk rests at CPOL.
- FINISH (1 clk): rx_data <= received byte, pending CS applied, busy=0 next cycle, then IDLE.
- MISO source: spi_miso of the lowest-index asserted CS; if none asserted, 1 (received byte = 8'hFF).
- dout = rx_data, combinational; oe = rx_re. A read during busy returns the previous rx_data and starts nothing.
- tx_we / rx_re while busy: ignored, no state change (the CPU must honour wait_n).
- cs_we:
  - cs_level=0 asserts spi_cs_n[cs_idx] and deasserts all others in the same cycle (exclusive).
  - cs_level=1 deasserts only that line.
  - cs_idx ≥ NUM_CS: ignored.
  - cs_we while busy: latched as pending (last write wins), applied in FINISH.
  - cs_we in the same cycle as a transfer start: applied before the first SCLK edge.
- div_we / mode_we: take effect only in IDLE; ignored while busy.
- mode_we in IDLE moves spi_clk to the new CPOL on the next clk.
- spi_mosi idles at 1 in IDLE.

Test Plan:
- Reset, then cs_we idx0 level0, tx_we din=8'hA5, div=0, mode0, device echoes 8'h3C.
  → spi_cs_n=2'b10; 16 clk of SHIFT; MOSI shifts 1,0,1,0,0,1,0,1; busy high 18 clk total; subsequent rx_re gives dout=8'h3C, oe=1.
- div_we div_in=3, mode_we mode_in=2'b11, tx_we 8'h81.
  → spi_clk idles 1; each half period = 4 clk; transfer = 64 clk in SHIFT; samples on rising edges.
- During busy: cs_we idx1 level0 and a second tx_we.
  → spi_cs_n unchanged until FINISH, then 2'b01; second byte is not sent.
- No CS asserted, rx_re.
  → starts a transfer with MOSI all 1s; next rx_re gives dout=8'hFF.
- Assert rst mid-SHIFT (bit 4).
  → same clk: busy=0, spi_cs_n all 1, spi_clk=CPOL, dout=8'hFF.
- tx_we and rx_re in the same cycle with rx_data=8'h55, din=8'h12.
  → dout=8'h55, MOSI transmits 8'h12.

Source files
------------

// File: rtl/spi_master_multi_if.sv
// CPU-side strobes and board SPI pins of spi_master_multi, bundled as one port.
interface spi_master_multi_if #(
    parameter int NUM_CS   = 2,
    parameter int CS_IDX_W = 1,
    parameter int DIV_W    = 8
);
    logic                cs_we;
    logic [CS_IDX_W-1:0] cs_idx;
    logic                cs_level;
    logic                div_we;
    logic [DIV_W-1:0]    div_in;
    logic                mode_we;
    logic [1:0]          mode_in;
    logic                tx_we;
    logic                rx_re;
    logic [7:0]          din;
    logic [7:0]          dout;
    logic                oe;
    logic                busy;
    logic                wait_n;
    logic                spi_clk;
    logic                spi_mosi;
    logic [NUM_CS-1:0]   spi_miso;
    logic [NUM_CS-1:0]   spi_cs_n;

    modport master (
        input  cs_we, cs_idx, cs_level, div_we, div_in, mode_we, mode_in,
               tx_we, rx_re, din, spi_miso,
        output dout, oe, busy, wait_n, spi_clk, spi_mosi, spi_cs_n
    );

    modport slave (
        output cs_we, cs_idx, cs_level, div_we, div_in, mode_we, mode_in,
               tx_we, rx_re, din, spi_miso,
        input  dout, oe, busy, wait_n, spi_clk, spi_mosi, spi_cs_n
    );
endinterface

// File: rtl/spi_master_multi.sv
// Byte-wide SPI master with programmable SCLK divider, modes 0-3 and
// mutually exclusive chip selects whose writes are deferred during a transfer.
module spi_master_multi #(
    parameter int              NUM_CS       = 2,
    parameter int              CS_IDX_W     = 1,
    parameter int              DIV_W        = 8,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = '0,
    parameter logic [1:0]      DEFAULT_MODE = 2'b00
) (
    input logic                clk,
    input logic                rst,
    spi_master_multi_if.master bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_e;

    state_e              state_q, state_d;
    logic                busy_q, busy_d;
    logic [7:0]          shreg_q, shreg_d;
    logic [7:0]          rxsh_q, rxsh_d;
    logic [7:0]          rx_q, rx_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [1:0]          mode_q, mode_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [4:0]          tog_q, tog_d;
    logic                sclk_q, sclk_d;
    logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
    logic                pend_q, pend_d;
    logic [CS_IDX_W-1:0] pend_idx_q, pend_idx_d;
    logic                pend_lvl_q, pend_lvl_d;

    logic [4:0] tog_k;
    logic       miso_sel, start, cfg_ok, cs_ok, sample;

    // Asserting one line releases all others; releasing touches only that line.
    function automatic logic [NUM_CS-1:0] cs_apply(input logic [NUM_CS-1:0] cur,
                                                    input logic [CS_IDX_W-1:0] idx,
                                                    input logic lvl);
        cs_apply = cur;
        for (int i = 0; i < NUM_CS; i++) begin
            if (int'(idx) == i)
                cs_apply[i] = lvl;
            else if (!lvl)
                cs_apply[i] = 1'b1;
        end
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            shreg_q    <= 8'hFF;
            rxsh_q     <= 8'hFF;
            rx_q       <= 8'hFF;
            div_q      <= DEFAULT_DIV;
            mode_q     <= DEFAULT_MODE;
            cnt_q      <= '0;
            tog_q      <= '0;
            sclk_q     <= DEFAULT_MODE[1];
            cs_n_q     <= '1;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
            pend_lvl_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            shreg_q    <= shreg_d;
            rxsh_q     <= rxsh_d;
            rx_q       <= rx_d;
            div_q      <= div_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            tog_q      <= tog_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
            pend_lvl_q <= pend_lvl_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        rxsh_d     = rxsh_q;
        rx_d       = rx_q;
        div_d      = div_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        tog_d      = tog_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        pend_d     = pend_q;
        pend_idx_d = pend_idx_q;
        pend_lvl_d = pend_lvl_q;

        miso_sel = 1'b1;
        for (int i = NUM_CS - 1; i >= 0; i--)
            if (!cs_n_q[i]) miso_sel = bus.spi_miso[i];

        cfg_ok = (state_q == IDLE) && !busy_q;
        start  = cfg_ok && (bus.tx_we || bus.rx_re);
        cs_ok  = bus.cs_we && (int'(bus.cs_idx) < NUM_CS);
        busy_d = (state_q != IDLE) || start;
        tog_k  = tog_q + 5'd1;
        sample = mode_q[0] ? ~tog_k[0] : tog_k[0];

        unique case (state_q)
            IDLE: begin
                if (cfg_ok && bus.div_we) div_d = bus.div_in;
                if (cfg_ok && bus.mode_we) begin
                    mode_d = bus.mode_in;
                    sclk_d = bus.mode_in[1];
                end
                if (cs_ok) cs_n_d = cs_apply(cs_n_q, bus.cs_idx, bus.cs_level);
                if (start) begin
                    shreg_d = bus.tx_we ? bus.din : 8'hFF;
                    rxsh_d  = 8'hFF;
                    cnt_d   = '0;
                    tog_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_ok) begin
                    pend_d     = 1'b1;
                    pend_idx_d = bus.cs_idx;
                    pend_lvl_d = bus.cs_level;
                end
                if (cnt_q == div_q) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    tog_d  = tog_k;
                    // CPHA=1 keeps bit 7 through the first (leading) edge.
                    if (sample)
                        rxsh_d = {rxsh_q[6:0], miso_sel};
                    else if (tog_k != 5'd1)
                        shreg_d = {shreg_q[6:0], 1'b1};
                    if (tog_k == 5'd16) state_d = FINISH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FINISH: begin
                rx_d = rxsh_q;
                if (cs_ok)
                    cs_n_d = cs_apply(cs_n_q, bus.cs_idx, bus.cs_level);
                else if (pend_q)
                    cs_n_d = cs_apply(cs_n_q, pend_idx_q, pend_lvl_q);
                pend_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.spi_clk  = sclk_q;
        bus.spi_mosi = (state_q == IDLE) ? 1'b1 : shreg_q[7];
        bus.spi_cs_n = cs_n_q;
        bus.busy     = busy_q;
        bus.wait_n   = ~busy_q;
        bus.dout     = rx_q;
        bus.oe       = bus.rx_re;
    end
endmodule

// File: tb/tb_spi_master_multi.sv
// Self-checking bench for spi_master_multi: behavioural SPI slaves plus a
// byte-level model of CS, divider, mode and receive data.
module tb_spi_master_multi;
    localparam int NCS = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_master_multi_if #(.NUM_CS(NCS), .CS_IDX_W(2), .DIV_W(8)) bus ();

    spi_master_multi #(
        .NUM_CS(NCS), .CS_IDX_W(2), .DIV_W(8),
        .DEFAULT_DIV(8'd0), .DEFAULT_MODE(2'b00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int             m_div = 0;
    logic [1:0]     m_mode = 2'b00;
    logic [NCS-1:0] m_cs = '1;
    logic [7:0]     m_rx = 8'hFF;
    logic [7:0]     dev_tx [NCS];

    int         bitcnt = 8;
    int         toggles = 0;
    logic [7:0] mosi_cap = 8'h00;
    logic [NCS-1:0] miso_v;

    // Slave side: every device shifts its own byte MSB first, changing after each sample edge.
    always_comb begin
        miso_v = '1;
        for (int i = 0; i < NCS; i++)
            if (bitcnt < 8) miso_v[i] = dev_tx[i][3'(7 - bitcnt)];
    end
    assign bus.spi_miso = miso_v;

    initial begin
        forever begin
            @(posedge bus.busy);
            bitcnt = 0; toggles = 0; mosi_cap = 8'h00;
            while (bus.busy === 1'b1) begin
                @(bus.spi_clk or negedge bus.busy);
                if (bus.busy === 1'b1) begin
                    toggles++;
                    if ((bus.spi_clk !== m_mode[1]) == (m_mode[0] == 1'b0)) begin
                        mosi_cap = {mosi_cap[6:0], bus.spi_mosi};
                        bitcnt++;
                    end
                end
            end
        end
    end

    function automatic logic [NCS-1:0] model_cs(input logic [NCS-1:0] cur, input int idx, input logic lvl);
        logic [NCS-1:0] r;
        if (idx >= NCS) return cur;
        if (lvl) begin
            r = cur;
            r[idx] = 1'b1;
        end else begin
            r = '1;
            r[idx] = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [7:0] model_rx(input logic [NCS-1:0] cs);
        for (int i = 0; i < NCS; i++)
            if (!cs[i]) return dev_tx[i];
        return 8'hFF;
    endfunction

    task automatic cs_write(input int idx, input logic lvl);
        @(negedge clk);
        bus.cs_idx = 2'(idx); bus.cs_level = lvl; bus.cs_we = 1'b1;
        @(negedge clk);
        bus.cs_we = 1'b0;
        m_cs = model_cs(m_cs, idx, lvl);
        n_checks++;
        if (bus.spi_cs_n !== m_cs) begin
            n_fail++;
            $display("FAIL cs_write idx=%0d lvl=%0b: spi_cs_n=%b expected %b", idx, lvl, bus.spi_cs_n, m_cs);
        end
    endtask

    task automatic cfg_write(input int div, input logic [1:0] mode);
        @(negedge clk);
        bus.div_in = 8'(div); bus.div_we = 1'b1;
        bus.mode_in = mode; bus.mode_we = 1'b1;
        @(negedge clk);
        bus.div_we = 1'b0; bus.mode_we = 1'b0;
        m_div = div; m_mode = mode;
        n_checks++;
        if (bus.spi_clk !== mode[1]) begin
            n_fail++;
            $display("FAIL cfg idle_sclk mode=%0d: spi_clk=%b expected %b", mode, bus.spi_clk, mode[1]);
        end
    endtask

    task automatic xfer(input logic tx, input logic rx, input logic [7:0] d, input string name);
        logic [7:0] exp_tx, exp_rx;
        int cyc;
        @(negedge clk);
        bus.tx_we = tx; bus.rx_re = rx; bus.din = d;
        #1;
        if (rx) begin
            n_checks++;
            if (bus.dout !== m_rx || bus.oe !== 1'b1) begin
                n_fail++;
                $display("FAIL %s read: dout=%h oe=%b expected dout=%h oe=1", name, bus.dout, bus.oe, m_rx);
            end
        end
        exp_tx = tx ? d : 8'hFF;
        exp_rx = model_rx(m_cs);
        @(negedge clk);
        bus.tx_we = 1'b0; bus.rx_re = 1'b0;
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 5000) begin
            cyc++;
            @(negedge clk);
        end
        n_checks++;
        if (cyc != 16 * (m_div + 1) + 2) begin
            n_fail++;
            $display("FAIL %s busy_len: %0d cycles expected %0d", name, cyc, 16 * (m_div + 1) + 2);
        end
        n_checks++;
        if (mosi_cap !== exp_tx || toggles != 16) begin
            n_fail++;
            $display("FAIL %s mosi: got %h with %0d sclk edges expected %h with 16", name, mosi_cap, toggles, exp_tx);
        end
        n_checks++;
        if (bus.spi_clk !== m_mode[1] || bus.spi_mosi !== 1'b1 || bus.spi_cs_n !== m_cs) begin
            n_fail++;
            $display("FAIL %s idle_pins: sclk=%b mosi=%b cs=%b expected sclk=%b mosi=1 cs=%b",
                     name, bus.spi_clk, bus.spi_mosi, bus.spi_cs_n, m_mode[1], m_cs);
        end
        m_rx = exp_rx;
        n_checks++;
        if (bus.dout !== m_rx) begin
            n_fail++;
            $display("FAIL %s rx_data: dout=%h expected %h", name, bus.dout, m_rx);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.wait_n !== 1'b1 || bus.spi_cs_n !== 3'b111 ||
            bus.spi_clk !== 1'b0 || bus.spi_mosi !== 1'b1 || bus.dout !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset: busy=%b wait_n=%b cs=%b sclk=%b mosi=%b dout=%h expected 0 1 111 0 1 ff",
                     bus.busy, bus.wait_n, bus.spi_cs_n, bus.spi_clk, bus.spi_mosi, bus.dout);
        end
        rst = 1'b0;
    endtask

    task automatic test_mode0_basic();
        dev_tx[0] = 8'h3C;
        cs_write(0, 1'b0);
        xfer(1'b1, 1'b0, 8'hA5, "mode0_a5");
        xfer(1'b0, 1'b1, 8'h00, "mode0_read");
    endtask

    task automatic test_mode3_div3();
        dev_tx[0] = 8'hC3;
        cfg_write(3, 2'b11);
        xfer(1'b1, 1'b0, 8'h81, "mode3_81");
    endtask

    task automatic test_busy_ignore();
        logic [7:0] exp_rx;
        int cyc;
        dev_tx[0] = 8'h96;
        exp_rx = model_rx(m_cs);
        @(negedge clk);
        bus.tx_we = 1'b1; bus.din = 8'h5A;
        @(negedge clk);
        bus.tx_we = 1'b0;
        repeat (10) @(negedge clk);
        bus.cs_we = 1'b1; bus.cs_idx = 2'd1; bus.cs_level = 1'b0;
        bus.tx_we = 1'b1; bus.din = 8'h00;
        @(negedge clk);
        bus.cs_we = 1'b0; bus.tx_we = 1'b0;
        n_checks++;
        if (bus.spi_cs_n !== m_cs) begin
            n_fail++;
            $display("FAIL busy_cs_deferred: cs=%b expected %b", bus.spi_cs_n, m_cs);
        end
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 5000) begin
            cyc++;
            @(negedge clk);
        end
        m_cs = model_cs(m_cs, 1, 1'b0);
        m_rx = exp_rx;
        n_checks++;
        if (bus.spi_cs_n !== m_cs || mosi_cap !== 8'h5A || bus.dout !== m_rx) begin
            n_fail++;
            $display("FAIL busy_finish: cs=%b mosi=%h dout=%h expected cs=%b mosi=5a dout=%h",
                     bus.spi_cs_n, mosi_cap, bus.dout, m_cs, m_rx);
        end
        repeat (8) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_second_tx: busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic test_no_cs_read();
        cs_write(1, 1'b1);
        cs_write(3, 1'b0);
        xfer(1'b0, 1'b1, 8'h00, "nocs_read1");
        xfer(1'b0, 1'b1, 8'h00, "nocs_read2");
    endtask

    task automatic test_simul_tx_rx();
        cfg_write(0, 2'b01);
        dev_tx[0] = 8'h55;
        cs_write(0, 1'b0);
        xfer(1'b1, 1'b0, 8'hE7, "simul_prep");
        dev_tx[0] = 8'hB4;
        xfer(1'b1, 1'b1, 8'h12, "simul_12");
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            int op;
            for (int i = 0; i < NCS; i++) dev_tx[i] = 8'($urandom);
            cfg_write(int'($urandom_range(0, 2)), 2'($urandom_range(0, 3)));
            cs_write(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            op = int'($urandom_range(1, 3));
            xfer(op[0], op[1], 8'($urandom), "random");
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        cfg_write(3, 2'b10);
        cs_write(0, 1'b0);
        @(negedge clk);
        bus.tx_we = 1'b1; bus.din = 8'hF0;
        @(negedge clk);
        bus.tx_we = 1'b0;
        cyc = 0;
        while (bitcnt < 4 && cyc < 2000) begin
            cyc++;
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (cyc >= 2000 || bus.busy !== 1'b0 || bus.spi_cs_n !== 3'b111 ||
            bus.spi_clk !== 1'b0 || bus.dout !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_mid: wait=%0d busy=%b cs=%b sclk=%b dout=%h expected busy=0 cs=111 sclk=0 dout=ff",
                     cyc, bus.busy, bus.spi_cs_n, bus.spi_clk, bus.dout);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_div = 0; m_mode = 2'b00; m_cs = '1; m_rx = 8'hFF;
        xfer(1'b1, 1'b1, 8'h3E, "after_reset");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cs_we = 1'b0; bus.cs_idx = '0; bus.cs_level = 1'b1;
        bus.div_we = 1'b0; bus.div_in = '0; bus.mode_we = 1'b0; bus.mode_in = '0;
        bus.tx_we = 1'b0; bus.rx_re = 1'b0; bus.din = '0;
        for (int i = 0; i < NCS; i++) dev_tx[i] = 8'hFF;
        test_reset();
        test_mode0_basic();
        test_mode3_div3();
        test_busy_ignore();
        test_no_cs_read();
        test_simul_tx_rx();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
